// File: rtl/axis_sgdma2ic_if.sv
// AXI-Stream bundle shared by the DMA control, DMA data and router sides of the bridge.
interface axis_sgdma2ic_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int DEST_WIDTH  = 4
);
    logic [TDATA_WIDTH-1:0]   tdata;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [DEST_WIDTH-1:0]    tdest;

    modport master (output tdata, tvalid, tlast, tkeep, tdest, input tready);
    modport slave  (input tdata, tvalid, tlast, tkeep, tdest, output tready);
endinterface

// File: rtl/axis_sgdma2ic.sv
// DMA MM2S to stream-router bridge: consumes one control descriptor, then forwards one
// data packet tagged with the APP0 destination.
module axis_sgdma2ic #(
    parameter int DATA_TDATA_WIDTH = 64,
    parameter int CTRL_TDATA_WIDTH = 32,
    parameter int DEST_WIDTH       = 4,
    parameter int PKT_CNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     arst,
    axis_sgdma2ic_if.slave           ctrl,
    axis_sgdma2ic_if.slave           data,
    axis_sgdma2ic_if.master          axis,
    input  logic                     err_clr,
    output logic                     desc_err,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count
);
    typedef enum logic [1:0] {S_CTRL, S_DATA, S_DRAIN} state_t;

    state_t                state, state_nxt;
    logic [2:0]            cnt;
    logic [DEST_WIDTH-1:0] dest_q;
    logic                  ctrl_hs, data_done, err_set;
    logic                  unused_sig;

    assign ctrl_hs   = ctrl.tvalid && ctrl.tready;
    assign data_done = (state == S_DATA) && data.tvalid && data.tready && data.tlast;

    assign axis.tdata = data.tdata;
    assign axis.tkeep = data.tkeep;
    assign axis.tlast = data.tlast;
    assign axis.tdest = dest_q;

    // tkeep of the control stream and the sideband tdest inputs carry no information here
    assign unused_sig = ^{ctrl.tkeep, ctrl.tdest, ctrl.tdata, data.tdest};

    always_comb begin
        state_nxt   = state;
        ctrl.tready = 1'b0;
        data.tready = 1'b0;
        axis.tvalid = 1'b0;
        err_set     = 1'b0;
        case (state)
            S_CTRL: begin
                ctrl.tready = 1'b1;
                if (ctrl_hs) begin
                    if (cnt == 3'd0 && ctrl.tdata[31:28] != 4'hA)
                        err_set = 1'b1;
                    if (cnt == 3'd5) begin
                        if (ctrl.tlast) begin
                            state_nxt = S_DATA;
                        end else begin
                            err_set   = 1'b1;
                            state_nxt = S_DRAIN;
                        end
                    end else if (ctrl.tlast) begin
                        err_set = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                ctrl.tready = 1'b1;
                if (ctrl_hs && ctrl.tlast)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                axis.tvalid = data.tvalid;
                data.tready = axis.tready;
                if (data_done)
                    state_nxt = S_CTRL;
            end
            default: state_nxt = S_CTRL;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= S_CTRL;
            cnt       <= 3'd0;
            dest_q    <= '0;
            desc_err  <= 1'b0;
            pkt_count <= '0;
        end else begin
            state <= state_nxt;
            if (err_set)
                desc_err <= 1'b1;
            else if (err_clr)
                desc_err <= 1'b0;
            if (state == S_CTRL && ctrl_hs) begin
                if (cnt == 3'd1)
                    dest_q <= ctrl.tdata[DEST_WIDTH-1:0];
                cnt <= (ctrl.tlast || cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
            end
            if (state == S_DRAIN && ctrl_hs && ctrl.tlast)
                cnt <= 3'd0;
            if (data_done)
                pkt_count <= pkt_count + PKT_CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_axis_sgdma2ic.sv
// Directed bench for axis_sgdma2ic: descriptor-level model plus per-beat scoreboard.
module tb_axis_sgdma2ic;
    logic       clk;
    logic       arst;
    logic       err_clr;
    logic       desc_err;
    logic [1:0] pkt_count;

    axis_sgdma2ic_if #(.TDATA_WIDTH(32), .DEST_WIDTH(4)) ctrl_if ();
    axis_sgdma2ic_if #(.TDATA_WIDTH(64), .DEST_WIDTH(4)) data_if ();
    axis_sgdma2ic_if #(.TDATA_WIDTH(64), .DEST_WIDTH(4)) axis_if ();

    axis_sgdma2ic #(
        .DATA_TDATA_WIDTH(64),
        .CTRL_TDATA_WIDTH(32),
        .DEST_WIDTH(4),
        .PKT_CNT_WIDTH(2)
    ) dut (
        .clk(clk),
        .arst(arst),
        .ctrl(ctrl_if),
        .data(data_if),
        .axis(axis_if),
        .err_clr(err_clr),
        .desc_err(desc_err),
        .pkt_count(pkt_count)
    );

    typedef logic [31:0] word_q_t[$];
    typedef struct {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
        logic [3:0]  tdest;
    } beat_t;

    beat_t      exp_q[$];
    logic       exp_err;
    logic [1:0] exp_cnt;
    logic [3:0] exp_dest;
    int         total;
    int         passed;
    bit         bp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp) axis_if.tready = ~axis_if.tready;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // scoreboard: every router handshake must match the next expected beat
    always @(negedge clk) begin
        beat_t b;
        if (!arst && axis_if.tvalid) begin
            chk("data_tready_follows", data_if.tready, axis_if.tready);
            chk("ctrl_tready_in_data", ctrl_if.tready, 1'b0);
            if (axis_if.tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: got tdata %0h expected no beat", axis_if.tdata);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_tdata", axis_if.tdata, b.tdata);
                    chk("beat_tkeep", axis_if.tkeep, b.tkeep);
                    chk("beat_tlast", axis_if.tlast, b.tlast);
                    chk("beat_tdest", axis_if.tdest, b.tdest);
                end
            end
        end
    end

    task automatic ctrl_beat(input logic [31:0] w, input bit last);
        int guard = 0;
        ctrl_if.tdata  = w;
        ctrl_if.tlast  = last;
        ctrl_if.tvalid = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (!ctrl_if.tready && guard < 200);
        if (guard >= 200) chk("ctrl_ready_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        ctrl_if.tvalid = 1'b0;
        ctrl_if.tlast  = 1'b0;
    endtask

    task automatic data_beat(input logic [63:0] d, input logic [7:0] k, input bit last);
        int guard = 0;
        data_if.tdata  = d;
        data_if.tkeep  = k;
        data_if.tlast  = last;
        data_if.tvalid = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (!data_if.tready && guard < 200);
        if (guard >= 200) chk("data_ready_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        data_if.tvalid = 1'b0;
        data_if.tlast  = 1'b0;
    endtask

    // Model: a descriptor is well-formed only with flag nibble A and exactly six words;
    // six or more words still release one packet; APP0 updates the dest whenever it arrives.
    task automatic send_desc(input word_q_t d, input bit clr_first, output bit fwd);
        for (int i = 0; i < d.size(); i++) begin
            if (i == 0 && clr_first) err_clr = 1'b1;
            ctrl_beat(d[i], i == d.size() - 1);
            err_clr = 1'b0;
        end
        if (clr_first) exp_err = 1'b0;
        if (d[0][31:28] != 4'hA || d.size() != 6) exp_err = 1'b1;
        if (d.size() >= 2) exp_dest = d[1][3:0];
        fwd = (d.size() >= 6);
    endtask

    task automatic send_pkt(input int n, input int tag, input int stop_after);
        beat_t b;
        for (int i = 0; i < n && i < stop_after; i++) begin
            b.tdata = {32'hC0DE_0000 | 32'(tag), 32'(i * 3 + 1)};
            b.tkeep = (i == n - 1) ? 8'h0F : 8'hFF;
            b.tlast = (i == n - 1);
            b.tdest = exp_dest;
            exp_q.push_back(b);
            data_beat(b.tdata, b.tkeep, b.tlast);
        end
        if (stop_after >= n) exp_cnt = exp_cnt + 2'd1;
    endtask

    task automatic run_case(input string name, input word_q_t d, input bit clr_first,
                            input int n, input int tag);
        bit fwd;
        send_desc(d, clr_first, fwd);
        if (fwd) send_pkt(n, tag, n);
        chk({name, "_desc_err"}, desc_err, exp_err);
        chk({name, "_pkt_count"}, pkt_count, exp_cnt);
        chk({name, "_tdest"}, axis_if.tdest, exp_dest);
    endtask

    task automatic clear_err(input string name);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        exp_err = 1'b0;
        chk(name, desc_err, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ctrl_tready"}, ctrl_if.tready, 1'b1);
        chk({name, "_data_tready"}, data_if.tready, 1'b0);
        chk({name, "_axis_tvalid"}, axis_if.tvalid, 1'b0);
        chk({name, "_axis_tdest"}, axis_if.tdest, 4'd0);
        chk({name, "_desc_err"}, desc_err, 1'b0);
        chk({name, "_pkt_count"}, pkt_count, 2'd0);
    endtask

    initial begin
        bit fwd;
        word_q_t good;
        total = 0; passed = 0; bp = 1'b0;
        exp_err = 1'b0; exp_cnt = 2'd0; exp_dest = 4'd0;
        arst = 1'b1; err_clr = 1'b0;
        ctrl_if.tdata = '0; ctrl_if.tvalid = 1'b0; ctrl_if.tlast = 1'b0;
        ctrl_if.tkeep = 4'hF; ctrl_if.tdest = '0;
        data_if.tdata = '0; data_if.tvalid = 1'b0; data_if.tlast = 1'b0;
        data_if.tkeep = '0; data_if.tdest = '0;
        axis_if.tready = 1'b1;

        #17;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        arst = 1'b0;

        // T1 nominal
        run_case("t1", '{32'hA000_0000, 32'h0000_0003, 0, 0, 0, 0}, 1'b0, 4, 1);
        chk("t1_lit_tdest", axis_if.tdest, 4'd3);
        chk("t1_lit_count", pkt_count, 2'd1);
        chk("t1_lit_err", desc_err, 1'b0);

        // T2 backpressure toggling each cycle
        bp = 1'b1;
        run_case("t2", '{32'hA000_0000, 32'h0000_0007, 1, 2, 3, 4}, 1'b0, 5, 2);
        bp = 1'b0;
        axis_if.tready = 1'b1;
        chk("t2_lit_count", pkt_count, 2'd2);

        // T3 short descriptor: no data may be accepted
        send_desc('{32'hA000_0000, 32'h0000_0009, 32'h0}, 1'b0, fwd);
        chk("t3_lit_err", desc_err, 1'b1);
        data_if.tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_no_data_ready", data_if.tready, 1'b0);
            chk("t3_no_axis_valid", axis_if.tvalid, 1'b0);
        end
        @(posedge clk);
        #1;
        data_if.tvalid = 1'b0;
        run_case("t3b", '{32'hA000_0000, 32'h0000_0005, 0, 0, 0, 0}, 1'b0, 3, 3);
        chk("t3_lit_tdest", axis_if.tdest, 4'd5);
        chk("t3_lit_err_sticky", desc_err, 1'b1);

        // T4 long descriptor drained, packet still forwarded; counter wraps to 0
        run_case("t4", '{32'hA000_0000, 32'h0000_000C, 0, 0, 0, 0, 32'h77, 32'h88}, 1'b0, 2, 4);
        chk("t4_lit_tdest", axis_if.tdest, 4'hC);
        chk("t4_lit_count_wrap", pkt_count, 2'd0);
        clear_err("t4_err_clr");

        // T5 bad flag with err_clr coinciding: set wins
        run_case("t5", '{32'h5000_0000, 32'h0000_0002, 0, 0, 0, 0}, 1'b1, 3, 5);
        chk("t5_lit_err", desc_err, 1'b1);
        clear_err("t5_err_clr");

        // T6 wrap after four packets from reset, then reset mid-packet
        @(posedge clk);
        #1;
        arst = 1'b1;
        exp_err = 1'b0; exp_cnt = 2'd0; exp_dest = 4'd0;
        #2;
        check_reset_outputs("t6_reset");
        @(posedge clk);
        #1;
        arst = 1'b0;
        good = '{32'hA000_0000, 32'h0000_0006, 0, 0, 0, 0};
        for (int p = 0; p < 4; p++) run_case("t6_pkt", good, 1'b0, 2, 10 + p);
        chk("t6_lit_wrap", pkt_count, 2'd0);
        send_desc('{32'hA000_0000, 32'h0000_000B, 0, 0, 0, 0}, 1'b0, fwd);
        send_pkt(4, 20, 2);
        axis_if.tready = 1'b0;
        data_if.tdata  = 64'hDEAD_BEEF_0000_0003;
        data_if.tvalid = 1'b1;
        #2;
        arst = 1'b1;
        #1;
        check_reset_outputs("t6_mid");
        @(posedge clk);
        #1;
        arst = 1'b0;
        data_if.tvalid = 1'b0;
        axis_if.tready = 1'b1;
        @(negedge clk);
        chk("t6_post_ctrl_tready", ctrl_if.tready, 1'b1);
        chk("t6_post_count", pkt_count, 2'd0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
